s_to_a_loader: RTL and testbench

Streaming loader that rebuilds the Keccak 5×5×64 lane array `A[x][y]` from the flat byte-ordered 1600-bit state/message image `S`. It performs the inverse mapping of the lane-to-flat packing used on the output side. Input arrives one 64-bit beat at a time over a valid/ready handshake. The assembled array is presented to the permutation core behind a second valid/ready handshake.

---
 rtl/s_to_a_loader_pkg.sv | 25 ++
 rtl/s_to_a_loader_bswap.sv | 11 +
 rtl/s_to_a_loader.sv | 110 +++++++++++
 tb/tb_s_to_a_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s_to_a_loader_pkg.sv
// Shared Keccak definitions: lane/state types, lane count, FSM states and
// the byte-swap used by both the flat-to-lane and lane-to-flat directions.
package s_to_a_loader_pkg;

    localparam int KECCAK_LANES = 25;

    typedef logic [63:0] lane_t;
    typedef lane_t [0:4][0:4] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } load_state_e;

    // The first S byte arrives in [63:56] but belongs in lane byte 0.
    function automatic lane_t lane_bswap(input lane_t v);
        lane_t r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = v[63-8*b -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/s_to_a_loader_bswap.sv
// Combinational 64-bit byte reverser turning an S beat into a Keccak lane.
module lane_bswap64
    import s_to_a_loader_pkg::*;
(
    input  logic [63:0] din,
    output logic [63:0] dout
);

    assign dout = lane_bswap(din);

endmodule

// File: rtl/s_to_a_loader.sv
// Streams 64-bit beats of the flat state image S into the 5x5 lane array A
// and hands complete blocks to the permutation core over valid/ready.
module s_to_a_loader
    import s_to_a_loader_pkg::*;
#(
    parameter int NUM_LANES = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_data,
    input  logic                    in_last,
    output logic                    a_valid,
    input  logic                    a_ready,
    output logic [0:4][0:4][63:0]   A,
    output logic [4:0]              a_lanes
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_LANES - 1);

    load_state_e state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic        accept;
    logic        consume;
    logic [63:0] swapped;

    lane_bswap64 u_bswap (
        .din  (in_data),
        .dout (swapped)
    );

    // in_ready depends on state and clear only, never on a_ready.
    assign in_ready = (state_reg != ST_FULL) && !clear;
    assign accept   = in_valid && in_ready;
    assign consume  = (state_reg == ST_FULL) && a_ready;
    assign a_valid  = (state_reg == ST_FULL);
    assign a_lanes  = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (clear) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        count_next = 5'd1;
                        state_next = (in_last || NUM_LANES == 1) ? ST_FULL : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        count_next = count_reg + 5'd1;
                        if (in_last || count_reg == LAST_IDX) begin
                            state_next = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (a_ready) begin
                        state_next = ST_IDLE;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Lanes are zeroed when a block is consumed, so short blocks read zero
    // in their unwritten lanes; lanes beyond NUM_LANES are tied to zero.
    genvar gi;
    generate
        for (gi = 0; gi < KECCAK_LANES; gi++) begin : g_lane
            if (gi < NUM_LANES) begin : g_live
                logic [63:0] lane_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        lane_reg <= '0;
                    end else if (clear || consume) begin
                        lane_reg <= '0;
                    end else if (accept && count_reg == 5'(gi)) begin
                        lane_reg <= swapped;
                    end
                end
                assign A[gi % 5][gi / 5] = lane_reg;
            end else begin : g_zero
                assign A[gi % 5][gi / 5] = '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_s_to_a_loader.sv
// Bench for s_to_a_loader: table-driven blocks checked through a scoreboard,
// plus hand-written back-pressure, clear, reset and single-lane sequences.
module tb_s_to_a_loader;
    import s_to_a_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n, clear, in_valid, in_ready, in_last, a_valid, a_ready;
    logic [63:0]           in_data;
    logic [0:4][0:4][63:0] A;
    logic [4:0]            a_lanes;

    logic                  clear1, in_valid1, in_ready1, in_last1, a_valid1, a_ready1;
    logic [63:0]           in_data1;
    logic [0:4][0:4][63:0] A1;
    logic [4:0]            a_lanes1;

    s_to_a_loader #(.NUM_LANES(25)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .a_valid(a_valid), .a_ready(a_ready), .A(A), .a_lanes(a_lanes)
    );

    s_to_a_loader #(.NUM_LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .a_valid(a_valid1), .a_ready(a_ready1), .A(A1), .a_lanes(a_lanes1)
    );

    typedef struct packed {
        logic [24:0][63:0] lanes;
        logic [4:0]        nl;
    } blk_t;

    typedef struct {
        int          nbeats;
        logic [63:0] base;
        bit          gaps;
        logic [4:0]  exp_lanes;
    } vec_t;

    blk_t sb[$];
    blk_t mon_e;
    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_blk = 0;
    logic [0:4][0:4][63:0] held;

    function automatic logic [63:0] ref_swap(input logic [63:0] v);
        return {<<8{v}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input bit last);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        check("beat_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom);
    endtask

    task automatic send_block(input int n, input logic [63:0] base, input bit gaps,
                              input logic [4:0] exp_lanes);
        blk_t e = '0;
        e.nl = exp_lanes;
        for (int i = 0; i < n; i++) e.lanes[i] = ref_swap(base ^ 64'(i));
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_beat(base ^ 64'(i), i == n - 1);
        end
        check("a_valid_latency", 64'(a_valid), 64'd1);
        check("a_lanes", 64'(a_lanes), 64'(exp_lanes));
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 50 && a_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(a_valid), 64'd0);
    endtask

    // Scoreboard side: every consumed block is compared lane by lane.
    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_block: got a_lanes %0d, required no block", a_lanes);
            end else begin
                mon_e = sb.pop_front();
                for (int i = 0; i < 25; i++) begin
                    check($sformatf("blk%0d_lane%0d", n_blk, i), A[i % 5][i / 5], mon_e.lanes[i]);
                end
                check($sformatf("blk%0d_a_lanes", n_blk), 64'(a_lanes), 64'(mon_e.nl));
                $display("block %0d consumed: a_lanes=%0d A[0][0]=%h", n_blk, a_lanes, A[0][0]);
                n_blk++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{17, 64'hA5A5_0000_1111_2222, 1'b0, 5'd17};
        vecs[1] = '{25, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd25};
        vecs[2] = '{6,  64'h8000_0000_0000_0001, 1'b1, 5'd6};
        vecs[3] = '{25, 64'hFFFF_FFFF_0000_0000, 1'b0, 5'd25};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; a_ready = 1'b1;
        clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; in_last1 = 1'b0; a_ready1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", 64'(a_valid), 64'd0);
        check("rst_a_lanes", 64'(a_lanes), 64'd0);
        check("rst_A_zero", 64'(A == '0), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Full block held in FULL under back-pressure.
        a_ready = 1'b0;
        send_block(25, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd25);
        check("A00_const", A[0][0], 64'hEFCDAB8967452301);
        check("A44_const", A[4][4], 64'hF7CDAB8967452301);
        held = A;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_last  = 1'($urandom);
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_a_valid", 64'(a_valid), 64'd1);
            check("bp_A_held", 64'(A == held), 64'd1);
            @(posedge clk);
            #1;
        end
        a_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_after_valid", 64'(a_valid), 64'd0);
        check("bp_after_zero", 64'(A == '0), 64'd1);
        send_block(1, 64'h1122_3344_5566_7788, 1'b0, 5'd1);
        wait_drain();

        for (int v = 0; v < 4; v++) begin
            send_block(vecs[v].nbeats, vecs[v].base, vecs[v].gaps, vecs[v].exp_lanes);
            wait_drain();
        end

        // clear arriving together with beat 7.
        for (int i = 0; i < 7; i++) drive_beat(64'hC0DE_0000_0000_0000 | 64'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0000_0007;
        in_last  = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_a_valid", 64'(a_valid), 64'd0);
        check("clr_A_zero", 64'(A == '0), 64'd1);
        check("clr_count", 64'(a_lanes), 64'd0);
        send_block(2, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 5'd2);
        wait_drain();

        // Asynchronous reset while FULL drops the block.
        a_ready = 1'b0;
        send_block(4, 64'h5555_AAAA_5555_AAAA, 1'b0, 5'd4);
        void'(sb.pop_back());
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstfull_a_valid", 64'(a_valid), 64'd0);
        check("rstfull_A_zero", 64'(A == '0), 64'd1);
        check("rstfull_a_lanes", 64'(a_lanes), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_ready = 1'b1;
        send_block(3, 64'h7777_6666_5555_4444, 1'b0, 5'd3);
        wait_drain();

        // NUM_LANES = 1: one beat without in_last completes the block.
        in_valid1 = 1'b1;
        in_data1  = 64'h0000_0000_0000_00FF;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("nl1_a_valid", 64'(a_valid1), 64'd1);
        check("nl1_A00", A1[0][0], 64'hFF00_0000_0000_0000);
        check("nl1_a_lanes", 64'(a_lanes1), 64'd1);
        check("nl1_A10", A1[1][0], 64'd0);
        in_valid1 = 1'b1;
        in_data1  = 64'h1234;
        a_ready1  = 1'b1;
        @(negedge clk);
        check("nl1_in_ready_full", 64'(in_ready1), 64'd0);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("nl1_consumed", 64'(a_valid1), 64'd0);
        check("nl1_zero", A1[0][0], 64'd0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
